// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: datapath width, register-file geometry and
// common typedefs used by the integer register file.
package rv32_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: x0 forces zero, then same-cycle writeback
// bypass, then the stored array contents.
module reg_file_read_port
  import rv32_pkg::*;
#(
  parameter int XLEN   = rv32_pkg::XLEN,
  parameter int NREGS  = rv32_pkg::NREGS,
  parameter int AW     = rv32_pkg::REG_AW,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]          i_rs_addr,
  input  logic [NREGS*XLEN-1:0]  i_regs_flat,
  input  logic                   i_wr_active,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [XLEN-1:0]        i_wr_data,
  output logic [XLEN-1:0]        o_rs_data
);

  logic w_is_zero;
  logic w_hit;

  assign w_is_zero = (i_rs_addr == AW'(REG_ZERO));
  assign w_hit     = (BYPASS != 0) && i_wr_active && (i_wr_addr == i_rs_addr);

  always_comb begin
    o_rs_data = i_regs_flat[i_rs_addr*XLEN +: XLEN];
    if (w_hit) begin
      o_rs_data = i_wr_data;
    end
    if (w_is_zero) begin
      o_rs_data = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// RV32I integer register file: 31 storage registers (x0 hardwired to zero),
// one synchronous write port and two combinational read ports.
module reg_file
  import rv32_pkg::*;
#(
  parameter int XLEN   = rv32_pkg::XLEN,
  parameter int NREGS  = rv32_pkg::NREGS,
  parameter int AW     = rv32_pkg::REG_AW,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            reg_write_enable,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  logic [XLEN-1:0]       r_regs [1:NREGS-1];
  logic [NREGS*XLEN-1:0] w_regs_flat;
  logic                  w_wr_active;

  // rst_n also qualifies the bypass so reads stay zero throughout reset.
  assign w_wr_active = reg_write_enable && rst_n && (rd_addr != AW'(REG_ZERO));

  assign w_regs_flat[XLEN-1:0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_regs[gi] <= '0;
        end else if (w_wr_active && (rd_addr == AW'(gi))) begin
          r_regs[gi] <= rd_data;
        end
      end
      assign w_regs_flat[gi*XLEN +: XLEN] = r_regs[gi];
    end
  endgenerate

  reg_file_read_port #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_rs1_port (
    .i_rs_addr   (rs1_addr),
    .i_regs_flat (w_regs_flat),
    .i_wr_active (w_wr_active),
    .i_wr_addr   (rd_addr),
    .i_wr_data   (rd_data),
    .o_rs_data   (rs1_data)
  );

  reg_file_read_port #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_rs2_port (
    .i_rs_addr   (rs2_addr),
    .i_regs_flat (w_regs_flat),
    .i_wr_active (w_wr_active),
    .i_wr_addr   (rd_addr),
    .i_wr_data   (rd_data),
    .o_rs_data   (rs2_data)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file; a BYPASS=1 and a BYPASS=0 instance share stimulus.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rd_data;
  logic        reg_write_enable;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] nb_rs1_data, nb_rs2_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_file #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .reg_write_enable(reg_write_enable),
    .rs1_data(rs1_data), .rs2_data(rs2_data)
  );

  reg_file #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .reg_write_enable(reg_write_enable),
    .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    rd_addr = a; rd_data = d; reg_write_enable = 1'b1;
    @(posedge clk); #1;
    reg_write_enable = 1'b0;
    $display("[TB] write x%0d <= %h", a, d);
  endtask

  initial begin
    rst_n = 1'b0;
    rs1_addr = '0; rs2_addr = '0; rd_addr = '0; rd_data = '0; reg_write_enable = 1'b0;
    #1;
    check("reset_rs1", rs1_data, 32'h0);
    check("reset_rs2", rs2_data, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // All registers read zero after reset
    for (int a = 1; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(32 - a); #1;
      check($sformatf("post_reset_rs1_x%0d", a), rs1_data, 32'h0);
      check($sformatf("post_reset_rs2_x%0d", 32 - a), rs2_data, 32'h0);
    end
    $display("[TB] reset sweep done");

    // Basic write/read
    do_write(5'd1, 32'd5);
    do_write(5'd2, 32'd10);
    rs1_addr = 5'd1; rs2_addr = 5'd2; #1;
    check("basic_rs1", rs1_data, 32'd5);
    check("basic_rs2", rs2_data, 32'd10);
    check("basic_nb_rs1", nb_rs1_data, 32'd5);
    check("basic_nb_rs2", nb_rs2_data, 32'd10);
    $display("[TB] read x1=%h x2=%h", rs1_data, rs2_data);

    // x0 protection including the bypass path
    @(negedge clk);
    rd_addr = 5'd0; rd_data = 32'hDEADBEEF; reg_write_enable = 1'b1;
    rs1_addr = 5'd0; rs2_addr = 5'd0; #1;
    check("x0_before_edge", rs1_data, 32'h0);
    check("x0_before_edge_rs2", rs2_data, 32'h0);
    @(posedge clk); #1;
    reg_write_enable = 1'b0; #1;
    check("x0_after_edge", rs1_data, 32'h0);
    check("x0_after_edge_nb", nb_rs1_data, 32'h0);
    $display("[TB] write x0 discarded, x0=%h", rs1_data);

    // Bypass versus stored value
    do_write(5'd3, 32'd7);
    @(negedge clk);
    rd_addr = 5'd3; rd_data = 32'd9; reg_write_enable = 1'b1;
    rs1_addr = 5'd3; rs2_addr = 5'd3; #1;
    check("bypass_rs1", rs1_data, 32'd9);
    check("bypass_rs2", rs2_data, 32'd9);
    check("nobypass_rs1", nb_rs1_data, 32'd7);
    check("nobypass_rs2", nb_rs2_data, 32'd7);
    @(posedge clk); #1;
    reg_write_enable = 1'b0; #1;
    check("bypass_after_edge", rs1_data, 32'd9);
    check("nobypass_after_edge", nb_rs1_data, 32'd9);
    $display("[TB] bypass x3: pre-edge 9/7, post-edge %h/%h", rs1_data, nb_rs1_data);

    // Write-enable gating and neighbours untouched
    @(negedge clk);
    rd_addr = 5'd4; rd_data = 32'd123; reg_write_enable = 1'b0;
    rs1_addr = 5'd4; rs2_addr = 5'd4; #1;
    check("we0_no_bypass", rs1_data, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    check("we0_rs1", rs1_data, 32'h0);
    check("we0_same_reg", rs2_data, rs1_data);
    rs1_addr = 5'd1; rs2_addr = 5'd2; #1;
    check("persist_x1", rs1_data, 32'd5);
    check("persist_x2", rs2_data, 32'd10);
    $display("[TB] we=0 gating x4=%h", rs1_data);

    // Asynchronous reset between edges, write attempted during reset
    do_write(5'd31, 32'hFFFFFFFF);
    @(negedge clk);
    rs1_addr = 5'd1; rs2_addr = 5'd31; #1;
    check("pre_reset_x1", rs1_data, 32'd5);
    check("pre_reset_x31", rs2_data, 32'hFFFFFFFF);
    #1;
    rst_n = 1'b0; #1;
    check("async_reset_rs1", rs1_data, 32'h0);
    check("async_reset_rs2", rs2_data, 32'h0);
    check("async_reset_nb_rs2", nb_rs2_data, 32'h0);
    rd_addr = 5'd5; rd_data = 32'd55; reg_write_enable = 1'b1; rs1_addr = 5'd5; #1;
    check("reset_no_bypass", rs1_data, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    reg_write_enable = 1'b0; rst_n = 1'b1; #1;
    check("reset_write_dropped", rs1_data, 32'h0);
    check("reset_cleared_x31", rs2_data, 32'h0);
    rs1_addr = 5'd1; #1;
    check("reset_cleared_x1", rs1_data, 32'h0);
    $display("[TB] async reset cleared x1/x31, write to x5 dropped");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry x 32-bit integer register file for the RV32I core, placed between decode and execute.
- Two asynchronous (combinational) read ports supply rs1/rs2 operands.
- One synchronous write port takes the writeback result.
- Register x0 is hardwired to zero; optional write-to-read bypass returns same-cycle writeback data.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers.
- AW, 5, address width (log2 NREGS).
- BYPASS, 1, 1 = read port returns rd_data when reading the register being written this cycle; 0 = returns stored value.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- rs1_addr  input  AW  read port 1 register index.
- rs2_addr  input  AW  read port 2 register index.
- rd_addr  input  AW  write port register index.
- rd_data  input  XLEN  write data.
- reg_write_enable  input  1  write strobe, sampled on rising clk.
- rs1_data  output  XLEN  contents of register rs1_addr.
- rs2_data  output  XLEN  contents of register rs2_addr.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: rst_n low immediately clears registers 1..NREGS-1 to 0, independent of clk. rs1_data/rs2_data read 0 while in reset. Writes are ignored while rst_n is low.
- Write: on rising clk with rst_n high, reg_write_enable=1 and rd_addr!=0 loads rd_data into regs[rd_addr]. Latency is 1 edge.
- Writes with rd_addr=0 are discarded; x0 has no storage, or any storage is never updated.
- Read: purely combinational, zero latency. rsN_data = 0 if rsN_addr==0, else regs[rsN_addr].
- Both ports are independent and may address the same register simultaneously.
- Bypass (BYPASS=1): if reg_write_enable=1, rd_addr!=0 and rsN_addr==rd_addr, rsN_data = rd_data combinationally, before the edge.
  - Priority: x0 zero > bypass > array.
  - With BYPASS=0 the old value is returned until after the edge.
- Writes to different registers do not disturb other entries. A value persists until overwritten or reset.
- Reset asserted mid-cycle while a write is pending: reset wins; no write occurs on an edge where rst_n is low.
- No X propagation: all addresses are in range (AW bits cover NREGS exactly), so no out-of-range case exists.

Decomposition:
- Shared package rv32_pkg holds:
  - XLEN=32, REG_AW=5, NREGS=32.
  - typedef reg_addr_t (logic [REG_AW-1:0]) and typedef xlen_t (logic [XLEN-1:0]).
  - constant REG_ZERO=5'd0.
- One sub-module is natural: reg_file_read_port. It holds the combinational zero/bypass/array mux and is instantiated twice, for rs1 and rs2.
- The storage array and write logic stay in reg_file.

Test Plan:
- Reset: rst_n=0 then 1, all addresses 0 and writes disabled -> rs1_data=rs2_data=0; after reset, reading addresses 1..31 returns 0.
- Basic write/read: write rd_addr=1, rd_data=5, we=1 for one edge, then rd_addr=2, rd_data=10, we=1; then we=0, rs1_addr=1, rs2_addr=2 -> rs1_data=5, rs2_data=10.
- x0 protection: write rd_addr=0, rd_data=32'hDEADBEEF, we=1 -> rs1_addr=0 reads 0 before and after the edge, including the bypass case.
- Bypass: regs[3]=7; present rd_addr=3, rd_data=9, we=1, rs1_addr=3 -> rs1_data=9 before the edge with BYPASS=1, 7 with BYPASS=0; 9 after the edge in both cases.
- Write enable gating: we=0, rd_addr=4, rd_data=123 across edges -> regs[4] stays 0; the same register on both ports gives rs1_data==rs2_data.
- Async reset mid-operation: regs[1]=5, regs[31]=32'hFFFFFFFF; drop rst_n between edges -> outputs go to 0 without a clk edge; a write presented during reset is not stored.
